// File: rtl/pipeline_control_unit.sv
// Stall/flush sequencer for the 5-stage pipeline: memory freeze, MEM-stage redirect, load-use interlock.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_control_unit #(
  parameter int LOAD_USE_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT           = 255,
  parameter int PERF_WIDTH            = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4:0]            id_rs,
  input  logic [4:0]            id_rt,
  input  logic                  id_usesRs,
  input  logic                  id_usesRt,
  input  logic                  ex_isLoad,
  input  logic                  ex_shouldWriteRegister,
  input  logic [4:0]            ex_writeAddress,
  input  logic                  mem_shouldBranch,
  input  logic                  mem_memRequest,
  input  logic                  mem_memReady,
  output logic                  pcEnable,
  output logic                  ifIdEnable,
  output logic                  ifIdFlush,
  output logic                  idExEnable,
  output logic                  idExFlush,
  output logic                  exMemEnable,
  output logic                  exMemFlush,
  output logic                  memWbEnable,
  output logic                  memTimeout,
  output logic [PERF_WIDTH-1:0] perfStallCycles,
  output logic [PERF_WIDTH-1:0] perfFlushEvents,
  output logic [PERF_WIDTH-1:0] perfMemWaitCycles
);

  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} stateT;

  localparam logic [1:0]  STALL_RELOAD  = 2'(LOAD_USE_STALL_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(MEM_TIMEOUT);

  stateT       stateReg, stateNext, savedStateReg, savedStateNext, resumeState;
  logic [1:0]  stallCountReg, stallCountNext, savedCountReg, savedCountNext, resumeCount;
  logic [15:0] timeoutCountReg, timeoutCountNext;
  logic        memTimeoutReg, memTimeoutNext;
  logic        hazLU, memBusy;

  assign hazLU = ex_isLoad & ex_shouldWriteRegister & (ex_writeAddress != 5'd0) &
                 ((id_usesRs & (id_rs == ex_writeAddress)) |
                  (id_usesRt & (id_rt == ex_writeAddress)));
  assign memBusy = mem_memRequest & ~mem_memReady;

  // A frozen cycle resumes whatever was running before the freeze.
  assign resumeState = (stateReg == MEM_WAIT) ? savedStateReg : stateReg;
  assign resumeCount = (stateReg == MEM_WAIT) ? savedCountReg : stallCountReg;

  always_comb begin
    pcEnable         = 1'b1;
    ifIdEnable       = 1'b1;
    ifIdFlush        = 1'b0;
    idExEnable       = 1'b1;
    idExFlush        = 1'b0;
    exMemEnable      = 1'b1;
    exMemFlush       = 1'b0;
    memWbEnable      = 1'b1;
    stateNext        = stateReg;
    stallCountNext   = stallCountReg;
    savedStateNext   = savedStateReg;
    savedCountNext   = savedCountReg;
    timeoutCountNext = 16'd0;
    memTimeoutNext   = memTimeoutReg;

    if (reset) begin
      pcEnable    = 1'b0;
      ifIdEnable  = 1'b0;
      ifIdFlush   = 1'b1;
      idExEnable  = 1'b0;
      idExFlush   = 1'b1;
      exMemEnable = 1'b0;
      exMemFlush  = 1'b1;
      memWbEnable = 1'b0;
    end else if (memBusy) begin
      pcEnable    = 1'b0;
      ifIdEnable  = 1'b0;
      idExEnable  = 1'b0;
      exMemEnable = 1'b0;
      memWbEnable = 1'b0;
      stateNext   = MEM_WAIT;
      if (stateReg != MEM_WAIT) begin
        savedStateNext = stateReg;
        savedCountNext = stallCountReg;
      end
      if (timeoutCountReg != 16'hFFFF) timeoutCountNext = timeoutCountReg + 16'd1;
      else                              timeoutCountNext = timeoutCountReg;
      if (timeoutCountNext >= TIMEOUT_LIMIT) memTimeoutNext = 1'b1;
    end else if (mem_shouldBranch) begin
      ifIdFlush      = 1'b1;
      idExFlush      = 1'b1;
      exMemFlush     = 1'b1;
      stateNext      = RUN;
      stallCountNext = 2'd0;
    end else if ((resumeState == LOAD_STALL) || hazLU) begin
      pcEnable   = 1'b0;
      ifIdEnable = 1'b0;
      idExFlush  = 1'b1;
      if (resumeState == LOAD_STALL) begin
        stallCountNext = resumeCount - 2'd1;
        stateNext      = (resumeCount <= 2'd1) ? RUN : LOAD_STALL;
      end else if (LOAD_USE_STALL_CYCLES > 1) begin
        stateNext      = LOAD_STALL;
        stallCountNext = STALL_RELOAD;
      end else begin
        stateNext      = RUN;
        stallCountNext = 2'd0;
      end
    end else begin
      stateNext      = RUN;
      stallCountNext = 2'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stateReg        <= RUN;
      stallCountReg   <= 2'd0;
      savedStateReg   <= RUN;
      savedCountReg   <= 2'd0;
      timeoutCountReg <= 16'd0;
      memTimeoutReg   <= 1'b0;
    end else begin
      stateReg        <= stateNext;
      stallCountReg   <= stallCountNext;
      savedStateReg   <= savedStateNext;
      savedCountReg   <= savedCountNext;
      timeoutCountReg <= timeoutCountNext;
      memTimeoutReg   <= memTimeoutNext;
    end
  end

  assign memTimeout = memTimeoutReg;

`ifdef PIPE_CTRL_PERF_EN
  logic [2:0] perfInc;

  // Index 0: load-use stall, 1: redirect, 2: freeze cycle.
  assign perfInc[0] = ~reset & ~memBusy & ~mem_shouldBranch & idExFlush;
  assign perfInc[1] = ~reset & ~memBusy & mem_shouldBranch;
  assign perfInc[2] = ~reset & memBusy;

  for (genvar gi = 0; gi < 3; gi++) begin : gPerf
    logic [PERF_WIDTH-1:0] countReg;
    always_ff @(posedge clock) begin
      if (reset)            countReg <= '0;
      else if (perfInc[gi]) countReg <= countReg + PERF_WIDTH'(1);
    end
  end

  assign perfStallCycles   = gPerf[0].countReg;
  assign perfFlushEvents   = gPerf[1].countReg;
  assign perfMemWaitCycles = gPerf[2].countReg;
`else
  assign perfStallCycles   = '0;
  assign perfFlushEvents   = '0;
  assign perfMemWaitCycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench for pipeline_control_unit: three instances (stall 1/2/3 cycles, timeout 255/3/255)
// share one stimulus stream; control outputs are compared as {pc,ifIdEn,ifIdFl,idExEn,idExFl,exMemEn,exMemFl,memWbEn}.
module tb_pipeline_control_unit;

  localparam logic [7:0] DEF = 8'b1101_0101;
  localparam logic [7:0] RST = 8'b0010_1010;
  localparam logic [7:0] FRZ = 8'b0000_0000;
  localparam logic [7:0] BR  = 8'b1111_1111;
  localparam logic [7:0] STL = 8'b0001_1101;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_writeAddress;
  logic       id_usesRs, id_usesRt, ex_isLoad, ex_shouldWriteRegister;
  logic       mem_shouldBranch, mem_memRequest, mem_memReady;

  wire [7:0]  ctl [3];
  wire        memTo [3];
  wire [31:0] pStall [3];
  wire [31:0] pFlush [3];
  wire [31:0] pWait [3];

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  for (genvar gi = 0; gi < 3; gi++) begin : gDut
    pipeline_control_unit #(
      .LOAD_USE_STALL_CYCLES(gi + 1),
      .MEM_TIMEOUT((gi == 1) ? 3 : 255),
      .PERF_WIDTH(32)
    ) dut (
      .clock(clock),
      .reset(reset),
      .id_rs(id_rs),
      .id_rt(id_rt),
      .id_usesRs(id_usesRs),
      .id_usesRt(id_usesRt),
      .ex_isLoad(ex_isLoad),
      .ex_shouldWriteRegister(ex_shouldWriteRegister),
      .ex_writeAddress(ex_writeAddress),
      .mem_shouldBranch(mem_shouldBranch),
      .mem_memRequest(mem_memRequest),
      .mem_memReady(mem_memReady),
      .pcEnable(ctl[gi][7]),
      .ifIdEnable(ctl[gi][6]),
      .ifIdFlush(ctl[gi][5]),
      .idExEnable(ctl[gi][4]),
      .idExFlush(ctl[gi][3]),
      .exMemEnable(ctl[gi][2]),
      .exMemFlush(ctl[gi][1]),
      .memWbEnable(ctl[gi][0]),
      .memTimeout(memTo[gi]),
      .perfStallCycles(pStall[gi]),
      .perfFlushEvents(pFlush[gi]),
      .perfMemWaitCycles(pWait[gi])
    );
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic checkCtl(input string tag, input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    logic [7:0] exp [3];
    exp = '{e0, e1, e2};
    for (int i = 0; i < 3; i++)
      checkEq($sformatf("%s.u%0d", tag, i), 32'(ctl[i]), 32'(exp[i]));
  endtask

  task automatic checkTo(input string tag, input logic e0, input logic e1, input logic e2);
    logic exp [3];
    exp = '{e0, e1, e2};
    for (int i = 0; i < 3; i++)
      checkEq($sformatf("%s.to%0d", tag, i), 32'(memTo[i]), 32'(exp[i]));
  endtask

  task automatic checkPerf(input string tag, input int s, input int f, input int w);
    for (int i = 0; i < 3; i++) begin
      checkEq($sformatf("%s.stall%0d", tag, i), pStall[i], 32'(s));
      checkEq($sformatf("%s.flush%0d", tag, i), pFlush[i], 32'(f));
      checkEq($sformatf("%s.wait%0d", tag, i), pWait[i], 32'(w));
    end
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_usesRs = 1'b0; id_usesRt = 1'b0;
    ex_isLoad = 1'b0; ex_shouldWriteRegister = 1'b0; ex_writeAddress = 5'd0;
    mem_shouldBranch = 1'b0; mem_memRequest = 1'b0; mem_memReady = 1'b0;
  endtask

  task automatic setHaz(input logic [4:0] addr, input logic [4:0] rs, input logic [4:0] rt,
                        input logic uRs, input logic uRt);
    idle();
    ex_isLoad = 1'b1; ex_shouldWriteRegister = 1'b1; ex_writeAddress = addr;
    id_rs = rs; id_rt = rt; id_usesRs = uRs; id_usesRt = uRt;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // After a one-cycle hazard: the 2- and 3-cycle instances keep stalling on their own.
  task automatic drainStall(input string tag);
    nextCycle(); idle(); #2; checkCtl({tag, "_c2"}, DEF, STL, STL);
    nextCycle(); idle(); #2; checkCtl({tag, "_c3"}, DEF, DEF, STL);
    nextCycle(); idle(); #2; checkCtl({tag, "_c4"}, DEF, DEF, DEF);
  endtask

  initial begin
    reset = 1'b1; idle(); #2;
    checkCtl("reset", RST, RST, RST);
    repeat (3) nextCycle();
    reset = 1'b0; idle(); #2;
    checkCtl("idle", DEF, DEF, DEF);
    checkTo("idle", 1'b0, 1'b0, 1'b0);
    checkPerf("idle", 0, 0, 0);

    nextCycle(); setHaz(5'd5, 5'd5, 5'd0, 1'b1, 1'b0); #2;
    checkCtl("lu_rs_c1", STL, STL, STL);
    drainStall("lu_rs");

    nextCycle(); setHaz(5'd7, 5'd0, 5'd7, 1'b0, 1'b1); #2;
    checkCtl("lu_rt_c1", STL, STL, STL);
    drainStall("lu_rt");

    nextCycle(); setHaz(5'd5, 5'd5, 5'd5, 1'b0, 1'b0); #2;
    checkCtl("no_use", DEF, DEF, DEF);
    nextCycle(); setHaz(5'd0, 5'd0, 5'd0, 1'b1, 1'b1); #2;
    checkCtl("r0", DEF, DEF, DEF);
    nextCycle(); setHaz(5'd9, 5'd9, 5'd0, 1'b1, 1'b0); ex_isLoad = 1'b0; #2;
    checkCtl("not_load", DEF, DEF, DEF);

    // Redirect wins over both the live hazard and a pending stall.
    nextCycle(); setHaz(5'd5, 5'd5, 5'd0, 1'b1, 1'b0); #2;
    checkCtl("br_c1", STL, STL, STL);
    nextCycle(); mem_shouldBranch = 1'b1; #2;
    checkCtl("br_c2", BR, BR, BR);
    nextCycle(); idle(); #2;
    checkCtl("br_c3", DEF, DEF, DEF);

    for (int k = 1; k <= 4; k++) begin
      nextCycle(); idle(); mem_memRequest = 1'b1; #2;
      checkCtl($sformatf("mw_c%0d", k), FRZ, FRZ, FRZ);
      checkTo($sformatf("mw_c%0d", k), 1'b0, (k >= 4), 1'b0);
    end
    nextCycle(); mem_memRequest = 1'b1; mem_memReady = 1'b1; #2;
    checkCtl("mw_c5", DEF, DEF, DEF);
    checkTo("mw_c5", 1'b0, 1'b1, 1'b0);
    nextCycle(); idle(); #2;
    checkTo("mw_sticky", 1'b0, 1'b1, 1'b0);

    // Freeze in the middle of a load-use stall resumes the remaining stall count.
    nextCycle(); setHaz(5'd3, 5'd3, 5'd0, 1'b1, 1'b0); #2;
    checkCtl("mls_c1", STL, STL, STL);
    nextCycle(); idle(); mem_memRequest = 1'b1; #2;
    checkCtl("mls_c2", FRZ, FRZ, FRZ);
    nextCycle(); mem_memRequest = 1'b1; mem_memReady = 1'b1; #2;
    checkCtl("mls_c3", DEF, STL, STL);
    nextCycle(); idle(); #2;
    checkCtl("mls_c4", DEF, DEF, STL);
    nextCycle(); idle(); #2;
    checkCtl("mls_c5", DEF, DEF, DEF);

    nextCycle(); reset = 1'b1; idle(); #2;
    checkCtl("rst2", RST, RST, RST);
    nextCycle(); reset = 1'b0; #2;
    checkTo("rst2", 1'b0, 1'b0, 1'b0);
    checkPerf("rst2", 0, 0, 0);

    // Two stall cycles, one redirect, four freeze cycles.
    nextCycle(); setHaz(5'd4, 5'd4, 5'd0, 1'b1, 1'b0); #2;
    nextCycle(); #2;
    checkCtl("pf_stall2", STL, STL, STL);
    nextCycle(); idle(); mem_shouldBranch = 1'b1; #2;
    for (int k = 0; k < 4; k++) begin
      nextCycle(); idle(); mem_memRequest = 1'b1; #2;
    end
    nextCycle(); mem_memRequest = 1'b1; mem_memReady = 1'b1; #2;
    nextCycle(); idle(); #2;
    checkPerf("perf", PERF_ON ? 2 : 0, PERF_ON ? 1 : 0, PERF_ON ? 4 : 0);
    nextCycle(); reset = 1'b1; #2;
    nextCycle(); reset = 1'b0; #2;
    checkPerf("perf_rst", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
